last_beat_tagger: RTL

- Successor block for attaching TLAST to GEM DMA write beats. It watches AW-channel beat addresses and the PS-signalled DMA-complete strobe, and emits one LAST/!LAST tag per previous beat.
- Generalises the single-buffer tagger in four ways:
  - a ring of NUM_BUFS receive buffers, each base counting as a packet start;
  - parametrised outstanding depth;
  - a backpressured tag output buffered by a FIFO;
  - DMA-complete coinciding with a beat is legal.
- Protocol violations are flagged instead of forbidden.
- Sits between the AW monitor and the TLAST side of the beat/tag join.

---
 rtl/last_beat_pkg.sv | 41 ++++
 rtl/last_beat_tagger_if.sv | 28 ++
 rtl/tag_fifo.sv | 67 ++++++
 rtl/last_beat_tagger.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/last_beat_pkg.sv
// Shared types and helpers for the last-beat tagger.
//   tag_t       : one tag bit (1 = last beat of a packet)
//   event_t     : classification of what happened on a given cycle
//   beat_bytes  : bytes per data beat for a given bus width
//   is_buf_base : true when a buffer-relative offset lands on a ring buffer base
package last_beat_pkg;

  typedef logic tag_t;

  localparam tag_t TAG_MID  = 1'b0;
  localparam tag_t TAG_LAST = 1'b1;

  typedef enum logic [3:0] {
    EV_NONE,        // nothing happens this cycle
    EV_DONE_LAST,   // complete only, one packet open: close previous beat
    EV_DONE_LATE,   // complete only, several open: previous beat already tagged
    EV_SPURIOUS,    // complete only, nothing open
    EV_WRAP_FIRST,  // base beat opening the very first packet
    EV_WRAP_NEXT,   // base beat: previous beat was the last of its packet
    EV_MID,         // ordinary beat inside a packet
    EV_ORPHAN,      // non-base beat with nothing open
    EV_WRAP_DONE,   // base beat and complete together
    EV_WRAP_SPUR,   // base beat and complete with nothing open
    EV_MID_DONE,    // ordinary beat and complete, several open
    EV_MID_TIE,     // ordinary beat and complete, one open: force a tie-off
    EV_MID_SPUR     // ordinary beat and complete with nothing open
  } event_t;

  function automatic int unsigned beat_bytes(input int unsigned bus_width);
    return bus_width / 8;
  endfunction

  // Offset must be buffer-relative (address minus ring base). The stride is a
  // power of two, so the modulo and divide reduce to bit slicing.
  function automatic logic is_buf_base(input logic [63:0] offset,
                                       input logic [63:0] stride,
                                       input logic [63:0] nbufs);
    return ((offset % stride) == 64'd0) && ((offset / stride) < nbufs);
  endfunction

endpackage

// File: rtl/last_beat_tagger_if.sv
// Handshake bundle between the AW monitor, the tagger and the tag consumer.
//   i_addr_data/i_addr_valid/i_addr_ready : beat address channel
//   i_dma_complete                        : one-cycle packet-done strobe
//   o_last/o_last_valid/o_last_ready      : tag channel
// slave is the tagger's view, master the surrounding logic's view.
interface last_beat_tagger_if #(
  parameter int ADDR_WIDTH = 32
) ();
  import last_beat_pkg::*;

  logic [ADDR_WIDTH-1:0] i_addr_data;
  logic                  i_addr_valid;
  logic                  i_addr_ready;
  logic                  i_dma_complete;
  tag_t                  o_last;
  logic                  o_last_valid;
  logic                  o_last_ready;

  modport slave (
    input  i_addr_data, i_addr_valid, i_dma_complete, o_last_ready,
    output i_addr_ready, o_last, o_last_valid
  );

  modport master (
    output i_addr_data, i_addr_valid, i_dma_complete, o_last_ready,
    input  i_addr_ready, o_last, o_last_valid
  );
endinterface

// File: rtl/tag_fifo.sv
// First-word-fall-through FIFO for 1-bit tags.
//   push/push_data : write one tag (dropped only if full with no pop)
//   pop            : consumer ready; a pop occurs when pop && pop_valid
//   pop_data       : head tag, forced to 0 while empty
//   pop_valid      : FIFO not empty
//   count          : current occupancy, 0..DEPTH
module tag_fifo
  import last_beat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  tag_t                       push_data,
  input  logic                       pop,
  output tag_t                       pop_data,
  output logic                       pop_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  tag_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign pop_valid = (count != '0);
  assign pop_data  = pop_valid ? mem[rd_ptr] : TAG_MID;
  assign do_pop    = pop && pop_valid;
  // At full a write is allowed when the head leaves in the same cycle; the
  // head is read combinationally before the edge, so sharing the slot is safe.
  assign do_push   = push && ((count != FULL_C) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && (count == FULL_C) && !do_pop));

endmodule

// File: rtl/last_beat_tagger.sv
// Attaches LAST/!LAST tags to DMA write beats.
// Each accepted beat address closes the tag of the beat before it: a beat on
// a ring buffer base (or a DMA-complete while exactly one packet is open)
// means the previous beat ended a packet. Tags queue in a FWFT FIFO.
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : address channel, complete strobe, tag channel
//   o_outstanding     : packets started but not yet completed
//   o_err_spurious    : sticky, complete seen with nothing outstanding
//   o_err_orphan      : sticky, non-base beat accepted with nothing outstanding
module last_beat_tagger
  import last_beat_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BUS_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_BUFS   = 4,
  parameter int                    BUF_STRIDE = 2048,
  parameter int                    CNT_WIDTH  = 2,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  last_beat_tagger_if.slave  bus,
  output logic [CNT_WIDTH:0] o_outstanding,
  output logic               o_err_spurious,
  output logic               o_err_orphan
);

  localparam int                    CW          = $clog2(FIFO_DEPTH + 1);
  localparam int                    BEAT_BYTES  = int'(beat_bytes(BUS_WIDTH));
  localparam logic [CNT_WIDTH:0]    MAX_OUT_C   = (CNT_WIDTH+1)'(2 ** CNT_WIDTH);
  localparam logic [CW-1:0]         FIFO_HI_C   = CW'(FIFO_DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES_C = ADDR_WIDTH'(BEAT_BYTES);

  logic [CNT_WIDTH:0]  start_cnt;
  logic [CNT_WIDTH:0]  done_cnt;
  logic [CNT_WIDTH:0]  outstanding;
  logic                armed;
  logic [CW-1:0]       fifo_count;
  logic [ADDR_WIDTH-1:0] offset;
  logic                wrap;
  logic                beat;
  logic                cplt;
  logic                o_zero;
  logic                o_one;
  event_t              ev;
  logic                push;
  tag_t                push_tag;
  logic                start_inc;
  logic                done_inc;
  logic                set_spur;
  logic                set_orph;
  tag_t                fifo_data;
  logic                fifo_valid;

  assign outstanding = start_cnt - done_cnt;
  assign o_zero      = (outstanding == '0);
  assign o_one       = (outstanding == (CNT_WIDTH+1)'(1));
  assign cplt        = bus.i_dma_complete;

  assign offset = bus.i_addr_data - BASE_ADDR;
  assign wrap   = bus.i_addr_valid &&
                  is_buf_base(64'(offset), 64'(BUF_STRIDE), 64'(NUM_BUFS));

  // armed holds ready low for the first cycle out of reset so every output,
  // ready included, reads 0 right after reset. The FIFO always keeps one
  // slot free for a complete-driven tie-off.
  assign bus.i_addr_ready = armed && (outstanding < MAX_OUT_C) &&
                            (fifo_count <= FIFO_HI_C);
  assign beat = bus.i_addr_valid && bus.i_addr_ready;

  always_comb begin
    ev = EV_NONE;
    if (beat) begin
      if (wrap) begin
        if (cplt) ev = o_zero ? EV_WRAP_SPUR : EV_WRAP_DONE;
        else      ev = o_zero ? EV_WRAP_FIRST : EV_WRAP_NEXT;
      end else begin
        if (cplt) ev = o_zero ? EV_MID_SPUR : (o_one ? EV_MID_TIE : EV_MID_DONE);
        else      ev = o_zero ? EV_ORPHAN : EV_MID;
      end
    end else if (cplt) begin
      ev = o_zero ? EV_SPURIOUS : (o_one ? EV_DONE_LAST : EV_DONE_LATE);
    end
  end

  always_comb begin
    push      = 1'b0;
    push_tag  = TAG_MID;
    start_inc = 1'b0;
    done_inc  = 1'b0;
    set_spur  = 1'b0;
    set_orph  = 1'b0;
    case (ev)
      EV_DONE_LAST:  begin push = 1'b1; push_tag = TAG_LAST; done_inc = 1'b1; end
      EV_DONE_LATE:  done_inc = 1'b1;
      EV_SPURIOUS:   set_spur = 1'b1;
      EV_WRAP_FIRST: start_inc = 1'b1;
      EV_WRAP_NEXT:  begin push = 1'b1; push_tag = TAG_LAST; start_inc = 1'b1; end
      EV_MID:        push = 1'b1;
      EV_ORPHAN:     set_orph = 1'b1;
      EV_WRAP_DONE:  begin
        push = 1'b1; push_tag = TAG_LAST; start_inc = 1'b1; done_inc = 1'b1;
      end
      EV_WRAP_SPUR:  begin start_inc = 1'b1; set_spur = 1'b1; end
      EV_MID_DONE:   begin push = 1'b1; done_inc = 1'b1; end
      // Only packet closes on a mid-packet beat: that beat must carry LAST.
      EV_MID_TIE:    begin
        push = 1'b1; push_tag = TAG_LAST; done_inc = 1'b1; set_orph = 1'b1;
      end
      EV_MID_SPUR:   begin set_orph = 1'b1; set_spur = 1'b1; end
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_cnt      <= '0;
      done_cnt       <= '0;
      armed          <= 1'b0;
      o_err_spurious <= 1'b0;
      o_err_orphan   <= 1'b0;
    end else begin
      armed     <= 1'b1;
      start_cnt <= start_cnt + {{CNT_WIDTH{1'b0}}, start_inc};
      done_cnt  <= done_cnt  + {{CNT_WIDTH{1'b0}}, done_inc};
      if (set_spur) o_err_spurious <= 1'b1;
      if (set_orph) o_err_orphan   <= 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_tag),
    .pop       (bus.o_last_ready),
    .pop_data  (fifo_data),
    .pop_valid (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.o_last       = fifo_data;
  assign bus.o_last_valid = fifo_valid;
  assign o_outstanding    = outstanding;

  a_out_bound : assert property (@(posedge clk) disable iff (reset)
    outstanding <= MAX_OUT_C);

  a_beat_aligned : assert property (@(posedge clk) disable iff (reset)
    bus.i_addr_valid |-> ((bus.i_addr_data % BEAT_BYTES_C) == '0));

  a_stall_stable : assert property (@(posedge clk) disable iff (reset)
    (bus.i_addr_valid && !bus.i_addr_ready) |=>
      (bus.i_addr_valid && $stable(bus.i_addr_data)));

endmodule
